// File: rtl/prng_request_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : prng_request_arbiter
// Purpose  : Round-robin sharing of three CA PRNG words among N_REQ requesters
// Revision : 1.0 - initial release
// ============================================================================
module prng_request_arbiter #(
   parameter int N_REQ  = 4,
   parameter int WIDTH  = 8,
   parameter int WARMUP = 16
) (
   input  logic                     i_clk,
   input  logic                     i_rst,
   input  logic [WIDTH-1:0]         i_rn_0,
   input  logic [WIDTH-1:0]         i_rn_1,
   input  logic [WIDTH-1:0]         i_rn_2,
   input  logic [N_REQ-1:0]         i_req,
   input  logic [2*N_REQ-1:0]       i_src,
   output logic [N_REQ-1:0]         o_ack,
   output logic [WIDTH*N_REQ-1:0]   o_data,
   output logic [N_REQ-1:0]         o_err,
   output logic                     o_ready
);

   localparam int               N_SRC       = 3;
   localparam int               PTR_W       = $clog2(N_REQ);
   localparam logic [PTR_W-1:0] PTR_LAST    = PTR_W'(N_REQ - 1);
   localparam logic [7:0]       WARM_LAST   = 8'(WARMUP);
   localparam logic [1:0]       SRC_ILLEGAL = 2'd3;

   typedef enum logic [0:0] {
      ST_WARMUP = 1'b0,
      ST_RUN    = 1'b1
   } state_t;

   state_t                 state;
   logic [7:0]             warm_cnt;
   logic [PTR_W-1:0]       ptr       [N_SRC];
   logic [WIDTH-1:0]       rn        [N_SRC];
   logic                   win_found [N_SRC];
   logic [PTR_W-1:0]       win_idx   [N_SRC];
   logic [N_REQ-1:0]       eligible;
   logic [N_REQ-1:0]       ack_next;
   logic [N_REQ-1:0]       err_next;
   logic [WIDTH*N_REQ-1:0] data_next;

   assign rn[0] = i_rn_0;
   assign rn[1] = i_rn_1;
   assign rn[2] = i_rn_2;

   // A requester holding its current pulse sits out one cycle.
   assign eligible = i_req & ~o_ack & ~o_err;

   function automatic int wrap(input int v);
      return (v >= N_REQ) ? v - N_REQ : v;
   endfunction

   always_comb begin : arbitrate
      int cand;
      cand = 0;
      for (int s = 0; s < N_SRC; s++) begin
         win_found[s] = 1'b0;
         win_idx[s]   = '0;
         for (int k = 0; k < N_REQ; k++) begin
            cand = wrap(int'(ptr[s]) + k);
            if (!win_found[s] && eligible[cand] && (i_src[2*cand +: 2] == 2'(s))) begin
               win_found[s] = 1'b1;
               win_idx[s]   = PTR_W'(cand);
            end
         end
      end
   end

   always_comb begin : next_outputs
      ack_next  = '0;
      err_next  = '0;
      data_next = o_data;
      for (int r = 0; r < N_REQ; r++) begin
         for (int s = 0; s < N_SRC; s++) begin
            if (win_found[s] && (win_idx[s] == PTR_W'(r))) begin
               ack_next[r]                 = 1'b1;
               data_next[r*WIDTH +: WIDTH] = rn[s];
            end
         end
         if (eligible[r] && (i_src[2*r +: 2] == SRC_ILLEGAL)) begin
            err_next[r] = 1'b1;
         end
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state    <= ST_WARMUP;
         warm_cnt <= '0;
         o_ack    <= '0;
         o_err    <= '0;
         o_data   <= '0;
         o_ready  <= 1'b0;
         for (int s = 0; s < N_SRC; s++) begin
            ptr[s] <= '0;
         end
      end else begin
         case (state)
            ST_WARMUP: begin
               warm_cnt <= warm_cnt + 8'd1;
               if ((warm_cnt + 8'd1) == WARM_LAST) begin
                  state   <= ST_RUN;
                  o_ready <= 1'b1;
               end
            end
            ST_RUN: begin
               o_ack  <= ack_next;
               o_err  <= err_next;
               o_data <= data_next;
               for (int s = 0; s < N_SRC; s++) begin
                  if (win_found[s]) begin
                     ptr[s] <= (win_idx[s] == PTR_LAST) ? '0 : win_idx[s] + 1'b1;
                  end
               end
            end
            default: state <= ST_WARMUP;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_prng_request_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_prng_request_arbiter
// Purpose  : Randomized and directed checks of prng_request_arbiter vs a model
// Revision : 1.0 - initial release
// ============================================================================
module tb_prng_request_arbiter;

   localparam int N_REQ  = 4;
   localparam int WIDTH  = 8;
   localparam int WARMUP = 16;

   logic                   clk = 1'b0;
   logic                   rst;
   logic [WIDTH-1:0]       rn0, rn1, rn2;
   logic [N_REQ-1:0]       req;
   logic [2*N_REQ-1:0]     src;
   logic [N_REQ-1:0]       ack, err;
   logic [WIDTH*N_REQ-1:0] data;
   logic                   ready;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   // Reference model state
   int                     m_cnt;
   bit                     m_run;
   int                     m_ptr [3];
   logic [N_REQ-1:0]       m_ack, m_err;
   logic [WIDTH*N_REQ-1:0] m_data;
   logic                   m_ready;

   always #5 clk = ~clk;

   prng_request_arbiter #(.N_REQ(N_REQ), .WIDTH(WIDTH), .WARMUP(WARMUP)) dut (
      .i_clk(clk), .i_rst(rst),
      .i_rn_0(rn0), .i_rn_1(rn1), .i_rn_2(rn2),
      .i_req(req), .i_src(src),
      .o_ack(ack), .o_data(data), .o_err(err), .o_ready(ready)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic model_reset();
      m_cnt = 0;
      m_run = 1'b0;
      for (int s = 0; s < 3; s++) m_ptr[s] = 0;
      m_ack   = '0;
      m_err   = '0;
      m_data  = '0;
      m_ready = 1'b0;
   endtask

   // One clock edge of the arbiter described by its rules, not its structure.
   task automatic model_step();
      logic [N_REQ-1:0] nack, nerr;
      logic [WIDTH-1:0] word;
      int r;
      if (!m_run) begin
         m_cnt++;
         if (m_cnt == WARMUP) begin
            m_run   = 1'b1;
            m_ready = 1'b1;
         end
         return;
      end
      nack = '0;
      nerr = '0;
      for (int s = 0; s < 3; s++) begin
         word = (s == 0) ? rn0 : (s == 1) ? rn1 : rn2;
         for (int k = 0; k < N_REQ; k++) begin
            r = (m_ptr[s] + k) % N_REQ;
            if (req[r] && !m_ack[r] && !m_err[r] && (int'(src[2*r +: 2]) == s)) begin
               nack[r] = 1'b1;
               m_data[r*WIDTH +: WIDTH] = word;
               m_ptr[s] = (r + 1) % N_REQ;
               break;
            end
         end
      end
      for (int q = 0; q < N_REQ; q++) begin
         if (req[q] && !m_ack[q] && !m_err[q] && (src[2*q +: 2] == 2'd3)) nerr[q] = 1'b1;
      end
      m_ack = nack;
      m_err = nerr;
   endtask

   task automatic tick();
      @(posedge clk);
      if (!rst) model_step();
      #1;
      check("ack", 64'(ack), 64'(m_ack));
      check("err", 64'(err), 64'(m_err));
      check("data", 64'(data), 64'(m_data));
      check("ready", 64'(ready), 64'(m_ready));
      cyc++;
      rn0 = 8'(cyc);
      rn1 = 8'($urandom);
      rn2 = 8'($urandom);
   endtask

   task automatic random_cycles(input int n);
      for (int i = 0; i < n; i++) begin
         req = 4'($urandom);
         src = 8'($urandom);
         tick();
      end
   endtask

   logic [WIDTH-1:0] cap0, cap1, cap2;

   initial begin
      rst = 1'b1;
      req = '0;
      src = '0;
      rn0 = '0;
      rn1 = '0;
      rn2 = '0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      check("reset_ack", 64'(ack), 64'h0);
      check("reset_data", 64'(data), 64'h0);
      check("reset_ready", 64'(ready), 64'h0);

      // Warm-up with all requesters asking for rule 30
      req = 4'b1111;
      src = 8'h00;
      rst = 1'b0;
      for (int e = 1; e <= WARMUP; e++) begin
         tick();
         if (e < WARMUP) begin
            check("warm_ready", 64'(ready), 64'h0);
            check("warm_noack", 64'(ack), 64'h0);
         end else begin
            check("warm_ready_rise", 64'(ready), 64'h1);
         end
      end
      tick();
      check("first_ack", 64'(|ack), 64'h1);

      // Single request on requester 0
      req = '0;
      tick();
      tick();
      req  = 4'b0001;
      src  = 8'h00;
      cap0 = rn0;
      tick();
      check("single_ack", 64'(ack), 64'h1);
      check("single_data", 64'(data[7:0]), 64'(cap0));
      req = '0;
      tick();
      tick();
      check("single_hold", 64'(data[7:0]), 64'(cap0));

      // All four on rule 60: strict rotation, one ack per cycle
      req = 4'b1111;
      src = 8'b01_01_01_01;
      tick();
      for (int i = 0; i < 8; i++) begin
         tick();
         check("rot_onehot", 64'($countones(ack)), 64'h1);
      end

      // One requester per source in the same cycle
      req = '0;
      tick();
      tick();
      req  = 4'b0111;
      src  = 8'b00_10_01_00;
      cap0 = rn0;
      cap1 = rn1;
      cap2 = rn2;
      tick();
      check("same_ack", 64'(ack), 64'h7);
      check("same_d0", 64'(data[7:0]), 64'(cap0));
      check("same_d1", 64'(data[15:8]), 64'(cap1));
      check("same_d2", 64'(data[23:16]), 64'(cap2));

      // Illegal source code on requester 3
      req = 4'b1000;
      src = 8'b11_00_00_00;
      for (int i = 0; i < 6; i++) begin
         tick();
         check("illegal_err", 64'(err[3]), 64'(i % 2 == 0));
         check("illegal_noack", 64'(ack[3]), 64'h0);
      end

      random_cycles(400);

      // Asynchronous reset between edges
      #2;
      rst = 1'b1;
      #1;
      model_reset();
      check("arst_ack", 64'(ack), 64'h0);
      check("arst_err", 64'(err), 64'h0);
      check("arst_data", 64'(data), 64'h0);
      check("arst_ready", 64'(ready), 64'h0);
      tick();
      req = 4'b1111;
      src = 8'b10_01_00_01;
      rst = 1'b0;
      for (int e = 1; e <= WARMUP; e++) begin
         tick();
         check("rewarm_noack", 64'(ack), 64'h0);
      end
      tick();
      check("rewarm_ack", 64'(|ack), 64'h1);

      random_cycles(300);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/prng_request_arbiter.md
Name: prng_request_arbiter

Overview:
- Shares the three free-running cellular-automaton PRNG outputs (rule 30, rule 60, rule 150 words) among N_REQ requesters.
- Each requester selects a source. The block arbitrates round-robin per source and returns a registered random word with a one-cycle ack.
- Guarantees each PRNG sample is delivered to at most one requester.
- Holds off all service for a warm-up period after reset so the automata can mix. Sits between High_arch_PRNG and its consumers.

Parameters:
- N_REQ, 4: number of requesters (2..8).
- WIDTH, 8: width of each PRNG word.
- WARMUP, 16: cycles after reset release before service starts (1..255).

Ports:
- i_clk, input, 1: clock; all state on rising edge.
- i_rst, input, 1: reset, asynchronous, active-high.
- i_rn_0, input, WIDTH: rule 30 word; new value every cycle.
- i_rn_1, input, WIDTH: rule 60 word.
- i_rn_2, input, WIDTH: rule 150 word.
- i_req, input, N_REQ: per-requester request level.
- i_src, input, 2*N_REQ: per-requester source code, bits [2r+1:2r]. 0 = rule 30, 1 = rule 60, 2 = rule 150, 3 = illegal.
- o_ack, output, N_REQ: one-cycle grant/data-valid pulse per requester.
- o_data, output, WIDTH*N_REQ: per-requester delivered word, slice [WIDTH*r +: WIDTH].
- o_err, output, N_REQ: one-cycle pulse for an illegal source code.
- o_ready, output, 1: warm-up complete.

Behaviour:
- Reset (asynchronous, i_rst=1):
  - o_ack, o_err, o_data, o_ready = 0.
  - Warm-up counter = 0; all round-robin pointers = 0; FSM = WARMUP.
- FSM has two states: WARMUP and RUN.
  - WARMUP: counter increments each cycle after i_rst deasserts. When it reaches WARMUP, the state moves to RUN and o_ready rises on that edge, i.e. the WARMUP-th rising edge after release.
  - Requests seen in WARMUP are ignored: no ack, no err, no pointer change.
  - RUN holds until reset.
- Eligibility in RUN, for requester r: eligible when i_req[r]=1 and o_ack[r]=0 and o_err[r]=0 (the current registered pulse excludes it for that cycle).
- Arbitration, each cycle in RUN, for each source s in {0,1,2}:
  - Candidates are eligible requesters with i_src code s.
  - Winner g is the first candidate at or after ptr[s], scanning cyclically.
  - On the edge: o_ack[g] <= 1, o_data slice g <= i_rn_s as sampled on that edge, ptr[s] <= (g+1) mod N_REQ.
  - With no candidate, ptr[s] is unchanged.
- Capacity: the three sources arbitrate independently, so up to 3 acks per cycle. A requester gets at most 1 ack per cycle.
- Uniqueness: one sample per source per cycle means no two acks ever carry the same (source, cycle) sample.
- Illegal code 3 on an eligible requester: o_err[r] <= 1 for one cycle. No ack, no data change, no pointer change.
- o_ack and o_err are single-cycle pulses. o_data slices hold their value until that requester's next ack.
- Latency: a request sampled on edge t is acked at edge t if uncontested; the ack is visible in the cycle after t.
- Requester protocol:
  - Hold i_req until the ack; dropping it earlier withdraws the request.
  - Holding i_req through the ack cycle is a new request, which is re-eligible the cycle after the ack. Max rate is 1 word per 2 cycles per requester.
- i_src is sampled every cycle; changing it while pending is legal and retargets the request.
- Starvation-free: with K contenders on one source, each is served within K cycles.
- Reset mid-operation: pending pulses are dropped, o_data clears, pointers reset, and warm-up restarts in full.

Test Plan:
- Reset then release with WARMUP=16 and i_req=4'b1111 held -> o_ready=0 and o_ack=0 for 15 edges; o_ready=1 at edge 16; first acks at edge 17.
- Bench drives i_rn_0 = cycle count. Requester 0, src=0, single request in RUN -> o_ack[0] pulses one cycle; o_data[7:0] equals the i_rn_0 value at the grant edge; o_data holds after req drops.
- All 4 requesters, src=1, held continuously -> acks rotate 0,1,2,3,0,... one per cycle. Each requester is acked every 4 cycles, and all delivered words are distinct consecutive i_rn_1 samples.
- Same-cycle requests: req0 src=0, req1 src=1, req2 src=2 -> all three acked on the same edge with i_rn_0, i_rn_1 and i_rn_2 respectively.
- req3 with src=3 held -> o_err[3] pulses every other cycle; o_ack[3] stays 0; pointers unchanged.
- i_rst asserted mid-traffic between clock edges -> all outputs 0 immediately, with no clock edge required. After release, 16 cycles of warm-up pass before any further ack.
